// File: rtl/ctrl_matmul_seq_if.sv
// Command and datapath-control bundle between the top-level command side and
// the matmul sequencer.
interface ctrl_matmul_seq_if #(
    parameter int ADDR_BW = 8,
    parameter int CNT_BW  = 8
) ();
    logic               start;
    logic [ADDR_BW-1:0] base_addr;
    logic [CNT_BW-1:0]  num_rows;
    logic               stall;
    logic               ub_rd_en;
    logic [ADDR_BW-1:0] ub_addr;
    logic               feed_valid;
    logic               out_valid;
    logic               busy;
    logic               done;

    modport master (
        output start, base_addr, num_rows, stall,
        input  ub_rd_en, ub_addr, feed_valid, out_valid, busy, done
    );

    modport slave (
        input  start, base_addr, num_rows, stall,
        output ub_rd_en, ub_addr, feed_valid, out_valid, busy, done
    );
endinterface

// File: rtl/ctrl_matmul_seq.sv
// Sequencer for one matrix-multiply pass: streams UB row reads into data setup,
// then waits out the skew/array drain and aligns the output-row valid strobe.
//
// state   | meaning
// S_IDLE  | waiting for an accepted start
// S_FEED  | issuing UB row reads, one per non-stalled cycle
// S_DRAIN | waiting DRAIN_CYCLES+1 cycles for the last row to leave the array
// S_DONE  | one-cycle completion pulse
module ctrl_matmul_seq #(
    parameter int MATRIX_SIZE  = 8,
    parameter int ADDR_BW      = 8,
    parameter int CNT_BW       = 8,
    parameter int DRAIN_CYCLES = 2*MATRIX_SIZE-1
) (
    input  logic              clk,
    input  logic              rstn,
    ctrl_matmul_seq_if.slave  bus
);

    localparam int DR_BW = $clog2(DRAIN_CYCLES+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_BW-1:0]      addr_q, addr_d;
    logic [CNT_BW-1:0]       rem_q, rem_d;
    logic [DR_BW-1:0]        drain_q, drain_d;
    logic                    feed_q;
    logic [DRAIN_CYCLES-1:0] pipe_q, pipe_d;
    logic                    rd_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            drain_q <= '0;
            feed_q  <= 1'b0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
            feed_q  <= rd_en;
            pipe_q  <= pipe_d;
        end
    end

    // rem_q counts reads still to issue; the address does not advance past
    // the final read so ub_addr keeps the last row address after FEED.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_rows != '0) begin
                        addr_d  = bus.base_addr;
                        rem_d   = bus.num_rows;
                        state_d = S_FEED;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FEED: begin
                rd_en = !bus.stall;
                if (!bus.stall) begin
                    if (rem_q == CNT_BW'(1)) begin
                        rem_d   = '0;
                        drain_d = DR_BW'(DRAIN_CYCLES);
                        state_d = S_DRAIN;
                    end else begin
                        rem_d  = rem_q - CNT_BW'(1);
                        addr_d = addr_q + ADDR_BW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - DR_BW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Delay line models the skew stage plus array latency for each fed row.
    generate
        if (DRAIN_CYCLES == 1) begin : g_pipe1
            always_comb pipe_d = feed_q;
        end else begin : g_pipen
            always_comb pipe_d = {pipe_q[DRAIN_CYCLES-2:0], feed_q};
        end
    endgenerate

    assign bus.ub_rd_en   = rd_en;
    assign bus.ub_addr    = addr_q;
    assign bus.feed_valid = feed_q;
    assign bus.out_valid  = pipe_q[DRAIN_CYCLES-1];
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_ctrl_matmul_seq.sv
// Directed bench for ctrl_matmul_seq: table of passes with hand-computed
// timing, plus reset, abort and back-to-back sequences.
module tb_ctrl_matmul_seq;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_fail;

    ctrl_matmul_seq_if #(.ADDR_BW(8), .CNT_BW(8)) bus ();

    ctrl_matmul_seq #(.MATRIX_SIZE(8), .ADDR_BW(8), .CNT_BW(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  num;
        logic [63:0] stall_m;
        logic [63:0] start_m;
        int          maxc;
        int          e_reads;
        int          e_frd;
        int          e_lrd;
        int          e_fov;
        int          e_lov;
        int          e_done;
    } vec_t;

    vec_t       vt [6];
    logic       rd_a   [0:599];
    logic       fv_a   [0:599];
    logic       ov_a   [0:599];
    logic       busy_a [0:599];
    logic       done_a [0:599];
    logic [7:0] addr_a [0:599];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_or();
        return int'({bus.ub_rd_en, bus.feed_valid, bus.out_valid, bus.busy, bus.done, bus.ub_addr});
    endfunction

    task automatic run_pass(input vec_t v);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = v.base;
        bus.num_rows  = v.num;
        bus.stall     = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= v.maxc; c++) begin
            bus.stall = (c < 64) ? v.stall_m[c[5:0]] : 1'b0;
            if (c < 64 && v.start_m[c[5:0]]) begin
                bus.start     = 1'b1;
                bus.base_addr = 8'hAA;
                bus.num_rows  = 8'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            rd_a[c]   = bus.ub_rd_en;
            fv_a[c]   = bus.feed_valid;
            ov_a[c]   = bus.out_valid;
            busy_a[c] = bus.busy;
            done_a[c] = bus.done;
            addr_a[c] = bus.ub_addr;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic check_pass(input int i, input vec_t v);
        int nrd, frd, lrd, nfv, nov, fov, lov, ndone, dcyc, k;
        int addr_err, busy_err, fv_err, ov_err;
        logic [7:0] ea;
        string p;
        nrd = 0; frd = 0; lrd = 0; nfv = 0; nov = 0; fov = 0; lov = 0;
        ndone = 0; dcyc = 0; k = 0;
        addr_err = 0; busy_err = 0; fv_err = 0; ov_err = 0;
        p = $sformatf("v%0d", i);
        for (int c = 1; c <= v.maxc; c++) begin
            if (c <= v.e_lrd) begin
                ea = v.base + 8'(k);
                if (addr_a[c] !== ea) addr_err++;
            end
            if (rd_a[c]) begin
                nrd++; k++;
                if (frd == 0) frd = c;
                lrd = c;
            end
            if (fv_a[c]) nfv++;
            if (ov_a[c]) begin
                nov++;
                if (fov == 0) fov = c;
                lov = c;
            end
            if (done_a[c]) begin
                ndone++;
                dcyc = c;
            end
            if (busy_a[c] !== (c <= v.e_done)) busy_err++;
            if (c >= 2 && fv_a[c] !== rd_a[c-1]) fv_err++;
            if (c > 15) begin
                if (ov_a[c] !== fv_a[c-15]) ov_err++;
            end else if (ov_a[c] !== 1'b0) begin
                ov_err++;
            end
        end
        chk({p, "_reads"},      nrd,      v.e_reads);
        chk({p, "_first_rd"},   frd,      v.e_frd);
        chk({p, "_last_rd"},    lrd,      v.e_lrd);
        chk({p, "_addr_errs"},  addr_err, 0);
        chk({p, "_feed_cnt"},   nfv,      int'(v.num));
        chk({p, "_fv_align"},   fv_err,   0);
        chk({p, "_ov_cnt"},     nov,      int'(v.num));
        chk({p, "_first_ov"},   fov,      v.e_fov);
        chk({p, "_last_ov"},    lov,      v.e_lov);
        chk({p, "_ov_align"},   ov_err,   0);
        chk({p, "_done_cnt"},   ndone,    1);
        chk({p, "_done_cyc"},   dcyc,     v.e_done);
        chk({p, "_busy_errs"},  busy_err, 0);
    endtask

    initial begin
        int dcyc;
        int ndone;
        n_chk  = 0;
        n_fail = 0;

        //        base   num     stall     start     maxc reads frd lrd fov lov done
        vt[0] = '{8'h10, 8'd8,   64'h0,    64'h0,    40,  8,    1,  8,  17, 24, 25};
        vt[1] = '{8'h20, 8'd4,   64'h40C,  64'h0,    35,  4,    1,  6,  17, 22, 23};
        vt[2] = '{8'hFE, 8'd4,   64'h0,    64'h0,    32,  4,    1,  4,  17, 20, 21};
        vt[3] = '{8'h00, 8'd0,   64'h0,    64'h0,    12,  0,    0,  0,  0,  0,  1};
        vt[4] = '{8'h40, 8'd5,   64'h0,    64'h408,  34,  5,    1,  5,  17, 21, 22};
        vt[5] = '{8'h00, 8'd255, 64'h0,    64'h0,    285, 255,  1,  255, 17, 271, 272};

        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        bus.base_addr = '0;
        bus.num_rows  = '0;

        // Reset held with random stimulus: all outputs must stay low.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.start     = 1'($urandom);
            bus.stall     = 1'($urandom);
            bus.base_addr = 8'($urandom);
            bus.num_rows  = 8'($urandom);
            @(negedge clk);
            chk("reset_outputs", outs_or(), 0);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rstn      = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_pass(vt[i]);
            check_pass(i, vt[i]);
        end

        // Abort mid-DRAIN: N=3 drains in cycles 4..19, reset lands in cycle 9.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 8'h30; bus.num_rows = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_busy_before", int'(bus.busy), 1);
        #2 rstn = 1'b0;
        #1;
        chk("abort_outputs", outs_or(), 0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Fresh pass after release (N=1, done cycle 18), then start right after done.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 8'h50; bus.num_rows = 8'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dcyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dcyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("b2b_first_done_cyc", dcyc, 18);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 8'h60; bus.num_rows = 8'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_busy",  int'(bus.busy),     1);
        chk("b2b_rd_en", int'(bus.ub_rd_en), 1);
        chk("b2b_addr",  int'(bus.ub_addr),  'h60);
        dcyc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.done) begin
                dcyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("b2b_second_done_cyc", dcyc, 19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
